// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for the pipelined barrel shifter.
// The master side (issue logic / consumer) drives operands and out_ready;
// the slave side (the shifter) drives in_ready and the result.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_carry;
    logic               out_zero;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL / SRL / SRA / ROR over the full shift range.
// Mux level k shifts by 2^k when shamt[k] is set; levels run LSB-first and a
// register follows every REG_EVERY levels plus the final level, so
// LATENCY = ceil(SHAMT_W / REG_EVERY). The whole pipe stalls while the output
// holds an unaccepted result.
// Optional feature: define SHIFTER_FLAGS_EN to get out_carry / out_zero;
// otherwise both are tied to 0 and the flag logic is not built.
module pipelined_barrel_shifter #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    pipelined_barrel_shifter_if.slave  bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int LATENCY = (SHAMT_W + REG_EVERY - 1) / REG_EVERY;

    logic advance;

    // Inputs seen by each pipeline stage: index 0 is the bus, index s>0 is
    // the register bank that follows stage s-1.
    logic               stg_valid [LATENCY];
    logic [WIDTH-1:0]   stg_data  [LATENCY];
    logic [SHAMT_W-1:0] stg_shamt [LATENCY];
    logic [1:0]         stg_op    [LATENCY];
`ifdef SHIFTER_FLAGS_EN
    logic               stg_carry [LATENCY];
`endif

    // A held, unaccepted output freezes every stage; bubbles are not squeezed.
    assign advance      = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = advance;

    assign stg_valid[0] = bus.in_valid;
    assign stg_data[0]  = bus.in_data;
    assign stg_shamt[0] = bus.in_shamt;
    assign stg_op[0]    = bus.in_op;
`ifdef SHIFTER_FLAGS_EN
    assign stg_carry[0] = 1'b0;
`endif

    genvar gi;

    // Mux levels. The first level of each stage reads the stage input,
    // later levels chain from the previous level's result.
    generate
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_level
            localparam int S = gi / REG_EVERY;
            localparam int A = 1 << gi;

            logic [WIDTH-1:0] cur;
            logic [WIDTH-1:0] res;
`ifdef SHIFTER_FLAGS_EN
            logic             cur_carry;
            logic             res_carry;
`endif

            if (gi % REG_EVERY == 0) begin : g_head
                assign cur = stg_data[S];
`ifdef SHIFTER_FLAGS_EN
                assign cur_carry = stg_carry[S];
`endif
            end else begin : g_chain
                assign cur = g_level[gi-1].res;
`ifdef SHIFTER_FLAGS_EN
                assign cur_carry = g_level[gi-1].res_carry;
`endif
            end

            // One shift-by-2^k level. The carry is the last bit pushed out by
            // the highest active level, which equals data[WIDTH-shamt] (left)
            // or data[shamt-1] (right). For ROR, cur[A-1] is the new MSB, and
            // the last active level fixes the final MSB, so the same tap
            // yields "result MSB" with 0 left in place when shamt = 0.
            always_comb begin
                res = cur;
`ifdef SHIFTER_FLAGS_EN
                res_carry = cur_carry;
`endif
                if (stg_shamt[S][gi]) begin
                    case (stg_op[S])
                        2'b00:   res = {cur[WIDTH-1-A:0], {A{1'b0}}};
                        2'b01:   res = {{A{1'b0}}, cur[WIDTH-1:A]};
                        2'b10:   res = {{A{cur[WIDTH-1]}}, cur[WIDTH-1:A]};
                        default: res = {cur[A-1:0], cur[WIDTH-1:A]};
                    endcase
`ifdef SHIFTER_FLAGS_EN
                    res_carry = (stg_op[S] == 2'b00) ? cur[WIDTH-A] : cur[A-1];
`endif
                end
            end
        end
    endgenerate

    // Pipeline registers: one bank after each group of REG_EVERY levels.
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            localparam int LAST = ((gi + 1) * REG_EVERY < SHAMT_W) ?
                                  ((gi + 1) * REG_EVERY - 1) : (SHAMT_W - 1);

            logic             valid_q;
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;
`ifdef SHIFTER_FLAGS_EN
            logic             carry_q;
            logic             carry_d;
            assign carry_d = g_level[LAST].res_carry;
`endif
            assign data_d = g_level[LAST].res;

            // Capture this stage's shifted data and valid whenever the pipe moves.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
`ifdef SHIFTER_FLAGS_EN
                    carry_q <= 1'b0;
`endif
                end else if (advance) begin
                    valid_q <= stg_valid[gi];
                    data_q  <= data_d;
`ifdef SHIFTER_FLAGS_EN
                    carry_q <= carry_d;
`endif
                end
            end

            if (gi < LATENCY - 1) begin : g_fwd
                logic [SHAMT_W-1:0] shamt_q;
                logic [1:0]         op_q;
                logic               unused_lo;

                // Shift amount and op travel alongside the data for later levels.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        shamt_q <= '0;
                        op_q    <= 2'b00;
                    end else if (advance) begin
                        shamt_q <= stg_shamt[gi];
                        op_q    <= stg_op[gi];
                    end
                end

                // Bits already consumed by earlier levels are not looked at again.
                assign unused_lo = ^shamt_q[(gi+1)*REG_EVERY-1:0];

                assign stg_valid[gi+1] = valid_q;
                assign stg_data[gi+1]  = data_q;
                assign stg_shamt[gi+1] = shamt_q;
                assign stg_op[gi+1]    = op_q;
`ifdef SHIFTER_FLAGS_EN
                assign stg_carry[gi+1] = carry_q;
`endif
            end
        end
    endgenerate

    assign bus.out_valid = g_stage[LATENCY-1].valid_q;
    assign bus.out_data  = g_stage[LATENCY-1].data_q;

`ifdef SHIFTER_FLAGS_EN
    logic out_zero_q;

    // Zero flag is registered alongside the final data so it stalls with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_zero_q <= 1'b0;
        end else if (advance) begin
            out_zero_q <= (g_level[SHAMT_W-1].res == '0);
        end
    end

    assign bus.out_carry = g_stage[LATENCY-1].carry_q;
    assign bus.out_zero  = out_zero_q;
`else
    assign bus.out_carry = 1'b0;
    assign bus.out_zero  = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter at WIDTH=32, REG_EVERY=2
// (LATENCY=3). Flag expectations follow SHIFTER_FLAGS_EN.
module tb_pipelined_barrel_shifter;
    localparam int WIDTH = 32;

`ifdef SHIFTER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  shamt;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_carry;
        logic        exp_zero;
    } vec_t;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    vec_t vecs [$];

    pipelined_barrel_shifter_if #(.WIDTH(WIDTH)) bus ();

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .REG_EVERY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic c, input logic z);
        chk({tag, ".valid"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, ".data"},  bus.out_data, d);
        chk({tag, ".carry"}, {31'b0, bus.out_carry}, {31'b0, c & FLAGS});
        chk({tag, ".zero"},  {31'b0, bus.out_zero},  {31'b0, z & FLAGS});
        $display("result %s data=%h carry=%b zero=%b", tag, bus.out_data, bus.out_carry, bus.out_zero);
    endtask

    task automatic drive(input logic [1:0] op, input logic [4:0] shamt, input logic [31:0] data);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_shamt = shamt;
        bus.in_data  = data;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Issue every vector in vecs back to back and check each result
    // exactly three cycles after it was presented.
    task automatic run_burst(input string tag);
        int n;
        n = vecs.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) drive(vecs[i].op, vecs[i].shamt, vecs[i].data);
            else       idle();
            tick();
            if (i >= 2)
                chk_out($sformatf("%s[%0d]", tag, i - 2), vecs[i-2].exp_data,
                        vecs[i-2].exp_carry, vecs[i-2].exp_zero);
        end
        idle();
        tick();
        chk({tag, ".drained"}, {31'b0, bus.out_valid}, 32'd0);
        vecs.delete();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_shamt  = 5'd0;
        bus.in_data   = 32'h0;
        bus.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst.out_data",  bus.out_data, 32'h0);
        chk("rst.out_carry", {31'b0, bus.out_carry}, 32'd0);
        chk("rst.out_zero",  {31'b0, bus.out_zero}, 32'd0);
        chk("rst.in_ready",  {31'b0, bus.in_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // 1. SRA 0x80000000 by 4, result three cycles later for one cycle
        drive(2'b10, 5'd4, 32'h8000_0000);
        tick();
        idle();
        chk("t1.lat1", {31'b0, bus.out_valid}, 32'd0);
        tick();
        chk("t1.lat2", {31'b0, bus.out_valid}, 32'd0);
        tick();
        chk_out("t1", 32'hF800_0000, 1'b0, 1'b0);
        tick();
        chk("t1.one_cycle", {31'b0, bus.out_valid}, 32'd0);

        // 2. Back-to-back SLL/SRL/ROR
        vecs.push_back('{2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0});
        vecs.push_back('{2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0});
        vecs.push_back('{2'b11, 5'd1,  32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0});
        run_burst("t2");

        // 3. Stall with out_ready low for five cycles, four ops issued
        bus.out_ready = 1'b0;
        drive(2'b00, 5'd1, 32'h1);
        tick();
        drive(2'b00, 5'd2, 32'h1);
        tick();
        drive(2'b00, 5'd3, 32'h1);
        tick();
        chk("t3.head_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("t3.in_ready_low", {31'b0, bus.in_ready}, 32'd0);
        drive(2'b00, 5'd4, 32'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("t3.hold%0d.data", i), bus.out_data, 32'h2);
            chk($sformatf("t3.hold%0d.valid", i), {31'b0, bus.out_valid}, 32'd1);
            chk($sformatf("t3.hold%0d.in_ready", i), {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t3.in_ready_back", {31'b0, bus.in_ready}, 32'd1);
        chk_out("t3[0]", 32'h2, 1'b0, 1'b0);
        tick();
        idle();
        chk_out("t3[1]", 32'h4, 1'b0, 1'b0);
        tick();
        chk_out("t3[2]", 32'h8, 1'b0, 1'b0);
        tick();
        chk_out("t3[3]", 32'h10, 1'b0, 1'b0);
        tick();
        chk("t3.drained", {31'b0, bus.out_valid}, 32'd0);

        // 4. Reset with three ops in flight
        drive(2'b01, 5'd1, 32'h10);
        tick();
        drive(2'b01, 5'd2, 32'h10);
        tick();
        drive(2'b01, 5'd3, 32'h10);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4.after_rst", {31'b0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t4.quiet%0d", i), {31'b0, bus.out_valid}, 32'd0);
        end
        drive(2'b11, 5'd4, 32'h0000_00AB);
        tick();
        idle();
        chk("t4.new_lat1", {31'b0, bus.out_valid}, 32'd0);
        tick();
        chk("t4.new_lat2", {31'b0, bus.out_valid}, 32'd0);
        tick();
        chk_out("t4.new", 32'hB000_000A, 1'b1, 1'b0);
        tick();
        chk("t4.drained", {31'b0, bus.out_valid}, 32'd0);

        // 5. Flag cases
        vecs.push_back('{2'b01, 5'd1, 32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0});
        vecs.push_back('{2'b00, 5'd1, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1});
        run_burst("t5");

        // 6. shamt = 0 for every op
        vecs.push_back('{2'b00, 5'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0});
        vecs.push_back('{2'b01, 5'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0});
        vecs.push_back('{2'b10, 5'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0});
        vecs.push_back('{2'b11, 5'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0});
        run_burst("t6");

        // Extra range and fill checks
        vecs.push_back('{2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{2'b11, 5'd8,  32'h1234_5678, 32'h7812_3456, 1'b0, 1'b0});
        vecs.push_back('{2'b01, 5'd16, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1, 1'b0});
        vecs.push_back('{2'b00, 5'd16, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0});
        vecs.push_back('{2'b10, 5'd5,  32'h4000_0020, 32'h0200_0001, 1'b0, 1'b0});
        vecs.push_back('{2'b11, 5'd31, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0});
        run_burst("tx");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
